// File: rtl/frv_trap_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module : frv_trap_seq_pkg
//  Brief  : Shared types and constants for the WB-stage trap sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
package frv_trap_seq_pkg;

  localparam logic [1:0] c_MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] c_MTVEC_VECTORED = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CSR   = 2'd1,
    S_REDIR = 2'd2
  } trap_state_e;

  function automatic logic [31:0] mk_mcause(input logic irq, input logic [30:0] code);
    return {irq, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frv_trap_seq_if.sv
`default_nettype none
// ============================================================================
//  Module : frv_trap_seq_if
//  Brief  : Pipeline/CSR/fetch signal bundle seen by the trap sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
interface frv_trap_seq_if #(
  parameter int CAUSE_W = 6
) ();
  logic               int_trap_req;
  logic [CAUSE_W-1:0] int_trap_cause;
  logic               int_trap_ack;
  logic               wb_valid;
  logic [31:0]        wb_pc;
  logic               wb_exc;
  logic [CAUSE_W-1:0] wb_exc_cause;
  logic [31:0]        wb_exc_tval;
  logic               wb_mret;
  logic               wb_ready;
  logic               wb_retire;
  logic [31:0]        csr_mtvec;
  logic [31:0]        csr_mepc;
  logic               csr_mpie;
  logic               csr_mie;
  logic               csr_trap_we;
  logic               csr_mret_we;
  logic [31:0]        csr_mepc_wdata;
  logic [31:0]        csr_mcause_wdata;
  logic [31:0]        csr_mtval_wdata;
  logic               csr_mie_wdata;
  logic               csr_mpie_wdata;
  logic               cf_req;
  logic [31:0]        cf_target;
  logic               cf_ack;
  logic               trap_busy;

  modport master (
    output int_trap_req, int_trap_cause, wb_valid, wb_pc, wb_exc, wb_exc_cause,
           wb_exc_tval, wb_mret, csr_mtvec, csr_mepc, csr_mpie, csr_mie, cf_ack,
    input  int_trap_ack, wb_ready, wb_retire, csr_trap_we, csr_mret_we,
           csr_mepc_wdata, csr_mcause_wdata, csr_mtval_wdata, csr_mie_wdata,
           csr_mpie_wdata, cf_req, cf_target, trap_busy
  );

  modport slave (
    input  int_trap_req, int_trap_cause, wb_valid, wb_pc, wb_exc, wb_exc_cause,
           wb_exc_tval, wb_mret, csr_mtvec, csr_mepc, csr_mpie, csr_mie, cf_ack,
    output int_trap_ack, wb_ready, wb_retire, csr_trap_we, csr_mret_we,
           csr_mepc_wdata, csr_mcause_wdata, csr_mtval_wdata, csr_mie_wdata,
           csr_mpie_wdata, cf_req, cf_target, trap_busy
  );
endinterface
`default_nettype wire

// File: rtl/frv_trap_target.sv
`default_nettype none
// ============================================================================
//  Module : frv_trap_target
//  Brief  : Combinational redirect target from mtvec (trap) or mepc (mret).
//  Rev    : 1.0  initial release
// ============================================================================
module frv_trap_target
  import frv_trap_seq_pkg::*;
#(
  parameter int CAUSE_W = 6,
  parameter bit VEC_EN  = 1'b1
) (
  input  wire logic [31:0]        i_mtvec,
  input  wire logic [31:0]        i_mepc,
  input  wire logic               i_is_int,
  input  wire logic               i_is_mret,
  input  wire logic [CAUSE_W-1:0] i_cause,
  output logic      [31:0]        o_target
);

  logic [31:0] w_base;
  logic [31:0] w_trap_tgt;

  assign w_base = {i_mtvec[31:2], 2'b00};

  generate
    if (VEC_EN) begin : g_vec
      logic [31:0] w_off;
      // Only interrupts vector; modes 2/3 fall back to direct.
      assign w_off      = {{(30-CAUSE_W){1'b0}}, i_cause, 2'b00};
      assign w_trap_tgt = (i_is_int && (i_mtvec[1:0] == c_MTVEC_VECTORED))
                        ? (w_base + w_off) : w_base;
    end else begin : g_direct
      assign w_trap_tgt = w_base;
    end
  endgenerate

  assign o_target = i_is_mret ? {i_mepc[31:1], 1'b0} : w_trap_tgt;

endmodule
`default_nettype wire

// File: rtl/frv_trap_seq.sv
`default_nettype none
// ============================================================================
//  Module : frv_trap_seq
//  Brief  : WB-stage trap sequencer: arbitrates interrupt/exception/mret,
//           writes trap CSRs and holds a redirect to fetch until acknowledged.
//  Rev    : 1.0  initial release
// ============================================================================
module frv_trap_seq
  import frv_trap_seq_pkg::*;
#(
  parameter int CAUSE_W = 6,
  parameter bit VEC_EN  = 1'b1
) (
  input wire logic      g_clk,
  input wire logic      g_reset,
  frv_trap_seq_if.slave bus
);

  trap_state_e r_state;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_target;
  logic        r_mie_wdata;
  logic        r_mpie_wdata;
  logic        r_trap_we;
  logic        r_mret_we;
  logic        r_cf_req;

  logic        w_boundary;
  logic        w_take_int;
  logic        w_take_exc;
  logic        w_take_mret;
  logic [30:0] w_int_code;
  logic [30:0] w_exc_code;
  logic [31:0] w_target;

  // An instruction boundary exists only in IDLE with a valid WB instruction.
  assign w_boundary  = (r_state == S_IDLE) && !g_reset && bus.wb_valid;
  assign w_take_int  = w_boundary && bus.int_trap_req;
  assign w_take_exc  = w_boundary && !bus.int_trap_req && bus.wb_exc;
  assign w_take_mret = w_boundary && !bus.int_trap_req && !bus.wb_exc && bus.wb_mret;
  assign w_int_code  = 31'(bus.int_trap_cause);
  assign w_exc_code  = 31'(bus.wb_exc_cause);

  frv_trap_target #(
    .CAUSE_W (CAUSE_W),
    .VEC_EN  (VEC_EN)
  ) u_target (
    .i_mtvec   (bus.csr_mtvec),
    .i_mepc    (bus.csr_mepc),
    .i_is_int  (bus.int_trap_req),
    .i_is_mret (!bus.int_trap_req && !bus.wb_exc),
    .i_cause   (bus.int_trap_cause),
    .o_target  (w_target)
  );

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state      <= S_IDLE;
      r_mepc       <= '0;
      r_mcause     <= '0;
      r_mtval      <= '0;
      r_target     <= '0;
      r_mie_wdata  <= 1'b0;
      r_mpie_wdata <= 1'b0;
      r_trap_we    <= 1'b0;
      r_mret_we    <= 1'b0;
      r_cf_req     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take_int || w_take_exc) begin
            r_state      <= S_CSR;
            r_trap_we    <= 1'b1;
            r_mepc       <= bus.wb_pc;
            r_mcause     <= w_take_int ? mk_mcause(1'b1, w_int_code)
                                       : mk_mcause(1'b0, w_exc_code);
            r_mtval      <= w_take_int ? 32'd0 : bus.wb_exc_tval;
            r_mie_wdata  <= 1'b0;
            r_mpie_wdata <= bus.csr_mie;
            r_target     <= w_target;
          end else if (w_take_mret) begin
            r_state      <= S_CSR;
            r_mret_we    <= 1'b1;
            r_mie_wdata  <= bus.csr_mpie;
            r_mpie_wdata <= 1'b1;
            r_target     <= w_target;
          end
        end
        S_CSR: begin
          r_trap_we <= 1'b0;
          r_mret_we <= 1'b0;
          r_cf_req  <= 1'b1;
          r_state   <= S_REDIR;
        end
        S_REDIR: begin
          if (bus.cf_ack) begin
            r_cf_req <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.int_trap_ack     = w_take_int;
  assign bus.wb_ready         = w_boundary;
  assign bus.wb_retire        = w_boundary && !bus.int_trap_req && !bus.wb_exc;
  assign bus.csr_trap_we      = r_trap_we;
  assign bus.csr_mret_we      = r_mret_we;
  assign bus.csr_mepc_wdata   = r_mepc;
  assign bus.csr_mcause_wdata = r_mcause;
  assign bus.csr_mtval_wdata  = r_mtval;
  assign bus.csr_mie_wdata    = r_mie_wdata;
  assign bus.csr_mpie_wdata   = r_mpie_wdata;
  assign bus.cf_req           = r_cf_req;
  assign bus.cf_target        = r_target;
  assign bus.trap_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frv_trap_seq.sv
`default_nettype none
// ============================================================================
//  Module : tb_frv_trap_seq
//  Brief  : Randomized scoreboard bench for the WB-stage trap sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_frv_trap_seq;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic g_reset;

  frv_trap_seq_if #(.CAUSE_W(CW)) bus ();

  frv_trap_seq #(.CAUSE_W(CW), .VEC_EN(1'b1)) dut (
    .g_clk   (clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // kind: 0 retire, 1 interrupt, 2 exception, 3 mret
  typedef struct {
    int          kind;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target;
    logic        mie_w;
    logic        mpie_w;
  } exp_t;

  exp_t q_hs[$];
  exp_t q_tr[$];
  exp_t m_e;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = -100;
  bit   hold_ack = 1'b0;
  logic prev_cf = 1'b0;
  logic [31:0] prev_tgt = 32'd0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic exp_t model(input bit irq, input logic [CW-1:0] ic, input bit exc,
                                 input logic [CW-1:0] ec, input logic [31:0] pc,
                                 input logic [31:0] tval, input bit mret,
                                 input logic [31:0] mtvec, input logic [31:0] mepc,
                                 input bit mie, input bit mpie);
    exp_t e;
    e.kind = 0; e.mepc = 0; e.mcause = 0; e.mtval = 0; e.target = 0;
    e.mie_w = 1'b0; e.mpie_w = 1'b0;
    if (irq) begin
      e.kind   = 1;
      e.mepc   = pc;
      e.mcause = 32'h8000_0000 + 32'(ic);
      e.mtval  = 0;
      e.target = mtvec - (mtvec % 4);
      if (mtvec % 4 == 1) e.target = e.target + 4 * 32'(ic);
      e.mpie_w = mie;
    end else if (exc) begin
      e.kind   = 2;
      e.mepc   = pc;
      e.mcause = 32'(ec);
      e.mtval  = tval;
      e.target = mtvec - (mtvec % 4);
      e.mpie_w = mie;
    end else if (mret) begin
      e.kind   = 3;
      e.target = mepc - (mepc % 2);
      e.mie_w  = mpie;
      e.mpie_w = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input bit irq, input logic [CW-1:0] ic, input bit exc,
                       input logic [CW-1:0] ec, input logic [31:0] pc,
                       input logic [31:0] tval, input bit mret);
    exp_t e;
    int   n;
    bus.wb_valid       = 1'b1;
    bus.int_trap_req   = irq;
    bus.int_trap_cause = ic;
    bus.wb_exc         = exc;
    bus.wb_exc_cause   = ec;
    bus.wb_pc          = pc;
    bus.wb_exc_tval    = tval;
    bus.wb_mret        = mret;
    e = model(irq, ic, exc, ec, pc, tval, mret, bus.csr_mtvec, bus.csr_mepc,
              bus.csr_mie, bus.csr_mpie);
    q_hs.push_back(e);
    if (e.kind != 0) q_tr.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.wb_ready) break;
      n++;
      if (n >= 60) begin
        chk("accept_timeout", 32'(n), 32'd0);
        finish_run();
      end
    end
    @(posedge clk); #1;
    bus.wb_valid     = 1'b0;
    bus.int_trap_req = 1'b0;
    bus.wb_exc       = 1'b0;
    bus.wb_mret      = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.trap_busy) break;
      n++;
      if (n >= 60) begin
        chk("idle_timeout", 32'(n), 32'd0);
        finish_run();
      end
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!g_reset) begin
      if (bus.wb_valid && bus.wb_ready) begin
        if (q_hs.size() == 0) begin
          chk("hs_unexpected", 32'd1, 32'd0);
        end else begin
          m_e = q_hs.pop_front();
          chk("int_trap_ack", 32'(bus.int_trap_ack), 32'(m_e.kind == 1));
          chk("wb_retire", 32'(bus.wb_retire), 32'(m_e.kind == 0 || m_e.kind == 3));
          if (m_e.kind != 0) acc_cyc = cyc;
        end
      end else if (!bus.wb_valid) begin
        chk("no_valid_quiet", 32'({bus.int_trap_ack, bus.wb_ready, bus.wb_retire}), 32'd0);
      end
      if (bus.trap_busy)
        chk("busy_stall", 32'({bus.wb_ready, bus.int_trap_ack}), 32'd0);
      if (bus.csr_trap_we || bus.csr_mret_we) begin
        chk("we_exclusive", 32'(bus.csr_trap_we && bus.csr_mret_we), 32'd0);
        chk("csr_latency", 32'(cyc - acc_cyc), 32'd1);
        if (q_tr.size() == 0) begin
          chk("csr_unexpected", 32'd1, 32'd0);
        end else begin
          m_e = q_tr[0];
          chk("csr_trap_we", 32'(bus.csr_trap_we), 32'(m_e.kind == 1 || m_e.kind == 2));
          chk("csr_mret_we", 32'(bus.csr_mret_we), 32'(m_e.kind == 3));
          chk("csr_mie_wdata", 32'(bus.csr_mie_wdata), 32'(m_e.mie_w));
          chk("csr_mpie_wdata", 32'(bus.csr_mpie_wdata), 32'(m_e.mpie_w));
          if (m_e.kind != 3) begin
            chk("mepc_wdata", bus.csr_mepc_wdata, m_e.mepc);
            chk("mcause_wdata", bus.csr_mcause_wdata, m_e.mcause);
            chk("mtval_wdata", bus.csr_mtval_wdata, m_e.mtval);
          end
        end
      end
      if (bus.cf_req && !prev_cf) begin
        chk("cf_latency", 32'(cyc - acc_cyc), 32'd2);
        if (q_tr.size() == 0) begin
          chk("cf_unexpected", 32'd1, 32'd0);
        end else begin
          m_e = q_tr.pop_front();
          chk("cf_target", bus.cf_target, m_e.target);
        end
      end else if (bus.cf_req && prev_cf) begin
        chk("cf_target_stable", bus.cf_target, prev_tgt);
      end
    end
    prev_cf  = g_reset ? 1'b0 : bus.cf_req;
    prev_tgt = bus.cf_target;
  end

  // Fetch side: random acceptance of redirects, suppressible for hold tests
  initial begin
    bus.cf_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.cf_ack = !hold_ack && ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    int   n;
    bit   irq, exc, mret;
    logic [31:0] mtvec;
    g_reset            = 1'b1;
    bus.int_trap_req   = 1'b0;
    bus.int_trap_cause = '0;
    bus.wb_valid       = 1'b0;
    bus.wb_pc          = '0;
    bus.wb_exc         = 1'b0;
    bus.wb_exc_cause   = '0;
    bus.wb_exc_tval    = '0;
    bus.wb_mret        = 1'b0;
    bus.csr_mtvec      = 32'h2000;
    bus.csr_mepc       = '0;
    bus.csr_mpie       = 1'b0;
    bus.csr_mie        = 1'b1;
    repeat (3) @(posedge clk);
    #1 g_reset = 1'b0;
    @(negedge clk);
    chk("rst_cf_req", 32'(bus.cf_req), 32'd0);
    chk("rst_cf_target", bus.cf_target, 32'd0);
    chk("rst_busy", 32'(bus.trap_busy), 32'd0);
    chk("rst_we", 32'({bus.csr_trap_we, bus.csr_mret_we}), 32'd0);
    chk("rst_mepc", bus.csr_mepc_wdata, 32'd0);
    chk("rst_mcause", bus.csr_mcause_wdata, 32'd0);
    chk("rst_mtval", bus.csr_mtval_wdata, 32'd0);
    chk("rst_mie_mpie", 32'({bus.csr_mie_wdata, bus.csr_mpie_wdata}), 32'd0);
    @(posedge clk); #1;

    // Directed cases
    drive(1'b1, 6'd11, 1'b0, 6'd0, 32'h100, 32'h0, 1'b0);
    wait_idle();
    bus.csr_mtvec = 32'h2001;
    drive(1'b1, 6'd7, 1'b0, 6'd0, 32'h104, 32'h0, 1'b0);
    wait_idle();
    bus.csr_mtvec = 32'h3000;
    drive(1'b1, 6'd3, 1'b1, 6'd2, 32'h200, 32'hDEAD, 1'b0);
    wait_idle();
    bus.csr_mepc = 32'h403;
    bus.csr_mpie = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h300, 32'h0, 1'b1);
    wait_idle();
    bus.csr_mie = 1'b0;
    drive(1'b0, 6'd0, 1'b1, 6'd13, 32'h304, 32'hBEEF, 1'b0);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h308, 32'h0, 1'b0);

    // Redirect held for several cycles while a second interrupt waits
    wait_idle();
    hold_ack = 1'b1;
    drive(1'b1, 6'd3, 1'b0, 6'd0, 32'h500, 32'h0, 1'b0);
    fork
      begin
        repeat (8) @(posedge clk);
        #1 hold_ack = 1'b0;
      end
    join_none
    drive(1'b1, 6'd11, 1'b0, 6'd0, 32'h504, 32'h0, 1'b0);

    // Reset while redirect is pending
    wait_idle();
    hold_ack = 1'b1;
    drive(1'b1, 6'd5, 1'b0, 6'd0, 32'h600, 32'h0, 1'b0);
    n = 0;
    while (!bus.cf_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("redir_reached", 32'(bus.cf_req), 32'd1);
    @(posedge clk); #1 g_reset = 1'b1;
    @(posedge clk); #1 g_reset = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    chk("rst_redir_cf_req", 32'(bus.cf_req), 32'd0);
    chk("rst_redir_busy", 32'(bus.trap_busy), 32'd0);
    chk("rst_redir_ack_we", 32'({bus.int_trap_ack, bus.csr_trap_we, bus.csr_mret_we}), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.int_trap_req = $urandom_range(0, 1) == 1;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        bus.int_trap_req = 1'b0;
      end
      if (!bus.trap_busy) begin
        mtvec         = $urandom;
        mtvec         = (mtvec & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        bus.csr_mtvec = mtvec;
        bus.csr_mepc  = $urandom;
        bus.csr_mie   = $urandom_range(0, 1) == 1;
        bus.csr_mpie  = $urandom_range(0, 1) == 1;
      end
      irq  = $urandom_range(0, 4) == 0;
      exc  = $urandom_range(0, 3) == 0;
      mret = $urandom_range(0, 3) == 0;
      drive(irq, CW'($urandom_range(0, 63)), exc, CW'($urandom_range(0, 63)),
            $urandom & 32'hFFFF_FFFC, $urandom, mret);
    end

    wait_idle();
    repeat (2) @(posedge clk);
    chk("hs_queue_empty", 32'(q_hs.size()), 32'd0);
    chk("trap_queue_empty", 32'(q_tr.size()), 32'd0);
    finish_run();
  end

endmodule
`default_nettype wire
